// File: rtl/tty_hex_rx.sv
// tty_hex_rx: console hex-word decoder.
// Consumes bytes from the UART receiver handshake and parses each line of
// ASCII hex digits into a right-aligned WIDTH-bit word. The word is held on a
// level handshake until the consumer takes it. Malformed lines raise a
// one-cycle err pulse with a sticky err_code, and the rest of the line is
// discarded up to its terminator.
module tty_hex_rx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ch_valid,
  input  logic [7:0]       ch,
  output logic             ch_take,
  output logic             word_ready,
  input  logic             word_valid,
  output logic [WIDTH-1:0] word,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int MAXDIG = WIDTH / 4;
  localparam int CNT_W  = $clog2(MAXDIG + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAXDIG);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no digits seen on this line yet
    ST_DIGITS = 2'd1,  // at least one digit accumulated
    ST_HOLD   = 2'd2,  // completed word presented to the consumer
    ST_SKIP   = 2'd3   // discarding a malformed line up to its terminator
  } state_t;

  // ---------------------------------------------------------------------
  // Byte classification helpers
  // ---------------------------------------------------------------------

  // True for 0-9, A-F and a-f.
  function automatic logic is_hex_digit(input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      hit = 1'b1;
    end else if ((c >= 8'h41) && (c <= 8'h46)) begin
      hit = 1'b1;
    end else if ((c >= 8'h61) && (c <= 8'h66)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

  // Nibble value of a hex digit. Letters have low nibble 1..6 in both
  // cases, so adding 9 maps them to 10..15. Non-digits map to 0.
  function automatic logic [3:0] hex_value(input logic [7:0] c);
    logic [3:0] v;
    v = 4'd0;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      v = c[3:0];
    end else if (((c >= 8'h41) && (c <= 8'h46)) ||
                 ((c >= 8'h61) && (c <= 8'h66))) begin
      v = c[3:0] + 4'd9;
    end else begin
      v = 4'd0;
    end
    return v;
  endfunction

  // Line feed or carriage return ends a line.
  function automatic logic is_terminator(input logic [7:0] c);
    return (c == 8'h0A) || (c == 8'h0D);
  endfunction

  // Underscore is a readability separator inside a number.
  function automatic logic is_separator(input logic [7:0] c);
    return (c == 8'h5F);
  endfunction

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] word_r;
  logic [WIDTH-1:0] word_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic [1:0]       err_code_r;
  logic [1:0]       err_code_nxt_s;

  logic             take_s;
  logic             byte_digit_s;
  logic             byte_term_s;
  logic             byte_sep_s;
  logic [3:0]       byte_val_s;
  logic [WIDTH-1:0] word_shift_s;

  // Bytes are only taken outside HOLD; upstream keeps the byte until then.
  assign ch_take      = (state_r != ST_HOLD);
  assign take_s       = ch_valid && ch_take;

  assign byte_digit_s = is_hex_digit(ch);
  assign byte_term_s  = is_terminator(ch);
  assign byte_sep_s   = is_separator(ch);
  assign byte_val_s   = hex_value(ch);

  // Append one nibble on the right; the top nibble falls off, which only
  // matters once the digit limit is reached and that case is rejected.
  assign word_shift_s = (word_r << 3'd4) | WIDTH'(byte_val_s);

  assign word_ready   = (state_r == ST_HOLD);
  assign word         = word_r;
  assign err          = err_r;
  assign err_code     = err_code_r;

  // Register the FSM state, the word accumulator and the error outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r    <= ST_IDLE;
      word_r     <= '0;
      count_r    <= CNT_ZERO;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_nxt_s;
      word_r     <= word_nxt_s;
      count_r    <= count_nxt_s;
      err_r      <= err_nxt_s;
      err_code_r <= err_code_nxt_s;
    end
  end

  // Next-state and datapath update for the line parser.
  always_comb begin
    state_nxt_s    = state_r;
    word_nxt_s     = word_r;
    count_nxt_s    = count_r;
    err_nxt_s      = 1'b0;
    err_code_nxt_s = err_code_r;

    case (state_r)
      ST_IDLE: begin
        if (!take_s) begin
          state_nxt_s = ST_IDLE;
        end else if (byte_digit_s) begin
          word_nxt_s  = WIDTH'(byte_val_s);
          count_nxt_s = CNT_ONE;
          state_nxt_s = ST_DIGITS;
        end else if (byte_term_s || byte_sep_s) begin
          // Blank lines, the second half of CRLF and stray separators
          // produce nothing.
          state_nxt_s = ST_IDLE;
        end else begin
          err_nxt_s      = 1'b1;
          err_code_nxt_s = ERR_BAD_CHAR;
          state_nxt_s    = ST_SKIP;
        end
      end

      ST_DIGITS: begin
        if (!take_s) begin
          state_nxt_s = ST_DIGITS;
        end else if (byte_digit_s) begin
          if (count_r < CNT_MAX) begin
            word_nxt_s  = word_shift_s;
            count_nxt_s = count_r + CNT_ONE;
          end else begin
            err_nxt_s      = 1'b1;
            err_code_nxt_s = ERR_OVERFLOW;
            state_nxt_s    = ST_SKIP;
          end
        end else if (byte_sep_s) begin
          state_nxt_s = ST_DIGITS;
        end else if (byte_term_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          err_nxt_s      = 1'b1;
          err_code_nxt_s = ERR_BAD_CHAR;
          state_nxt_s    = ST_SKIP;
        end
      end

      ST_HOLD: begin
        if (word_valid) begin
          word_nxt_s  = '0;
          count_nxt_s = CNT_ZERO;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end

      ST_SKIP: begin
        if (take_s && byte_term_s) begin
          word_nxt_s  = '0;
          count_nxt_s = CNT_ZERO;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SKIP;
        end
      end

      default: begin
        word_nxt_s  = '0;
        count_nxt_s = CNT_ZERO;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

endmodule
